// File: rtl/vid_timing_gen.sv
// Raster timing generator: free-running h/v counters, registered sync/enable strobes
// and a selectable test pattern (colour bars, gray ramp, checkerboard, solid white).
module vid_timing_gen #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int KH       = 30,
    parameter int KV       = 30
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [1:0]                 pattern_i,
    output logic                       hs_o,
    output logic                       vs_o,
    output logic                       de_o,
    output logic [23:0]                data_o,
    output logic [$clog2(H_TOTAL)-1:0] x_o,
    output logic [$clog2(V_TOTAL)-1:0] y_o,
    output logic                       sof_o
);

    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int HCW   = (HW < 8) ? 8 : HW;  // keep h[7:0] addressable for the ramp
    localparam int BAR_W = (H_WIDTH >= 8) ? H_WIDTH / 8 : 1;
    localparam int BCW   = $clog2(BAR_W + 1);
    localparam int KXW   = $clog2(KH + 1);
    localparam int KYW   = $clog2(KV + 1);

    generate
        if (!(H_WIDTH < H_START && H_START + H_SYNC <= H_TOTAL &&
              V_HEIGHT < V_START && V_START + V_SYNC <= V_TOTAL)) begin : g_bad_timing
            $error("vid_timing_gen: illegal timing parameters");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        sof;
        logic [23:0] data;
    } vout_t;

    state_t         state_q, state_d;
    logic [1:0]     pat_q;
    logic [HCW-1:0] h;
    logic [VW-1:0]  v;
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;
    logic [KXW-1:0] kx_cnt;
    logic [KYW-1:0] ky_cnt;
    logic           bx, by;
    int             hi, vi;
    logic           line_end, frame_end, pat_load;
    vout_t          vo;

    assign hi        = int'(h);
    assign vi        = int'(v);
    assign line_end  = (hi == H_TOTAL - 1);
    assign frame_end = line_end && (vi == V_TOTAL - 1);

    always_comb begin
        state_d  = state_q;
        pat_load = 1'b0;
        case (state_q)
            IDLE: if (en_i) begin
                state_d  = RUN;
                pat_load = 1'b1;
            end
            RUN: if (frame_end) begin
                state_d  = en_i ? RUN : IDLE;
                pat_load = en_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pat_q   <= 2'd0;
            h       <= '0;
            v       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            kx_cnt  <= '0;
            bx      <= 1'b0;
            ky_cnt  <= '0;
            by      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pat_load) pat_q <= pattern_i;
            if (state_q != RUN) begin
                h       <= '0;
                v       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                kx_cnt  <= '0;
                bx      <= 1'b0;
                ky_cnt  <= '0;
                by      <= 1'b0;
            end else if (line_end) begin
                h       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                kx_cnt  <= '0;
                bx      <= 1'b0;
                if (frame_end) begin
                    v      <= '0;
                    ky_cnt <= '0;
                    by     <= 1'b0;
                end else begin
                    v <= v + VW'(1);
                    if (int'(ky_cnt) == KV - 1) begin
                        ky_cnt <= '0;
                        by     <= ~by;
                    end else begin
                        ky_cnt <= ky_cnt + KYW'(1);
                    end
                end
            end else begin
                h <= h + HCW'(1);
                // Last bar saturates, absorbing any remainder pixels.
                if (bar_idx != 3'd7) begin
                    if (int'(bar_cnt) == BAR_W - 1) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + BCW'(1);
                    end
                end
                if (int'(kx_cnt) == KH - 1) begin
                    kx_cnt <= '0;
                    bx     <= ~bx;
                end else begin
                    kx_cnt <= kx_cnt + KXW'(1);
                end
            end
        end
    end

    always_comb begin
        vo      = '0;
        vo.de   = (hi < H_WIDTH) && (vi < V_HEIGHT);
        vo.hs   = (hi >= H_START && hi < H_START + H_SYNC) ? HS_POL : ~HS_POL;
        vo.vs   = (vi >= V_START && vi < V_START + V_SYNC) ? VS_POL : ~VS_POL;
        vo.sof  = vo.de && (hi == 0) && (vi == 0);
        if (vo.de) begin
            case (pat_q)
                // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
                2'd0:    vo.data = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
                2'd1:    vo.data = {3{h[7:0]}};
                2'd2:    vo.data = (bx ^ by) ? 24'h000000 : 24'hFFFFFF;
                default: vo.data = 24'hFFFFFF;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_o   <= ~HS_POL;
            vs_o   <= ~VS_POL;
            de_o   <= 1'b0;
            sof_o  <= 1'b0;
            data_o <= '0;
            x_o    <= '0;
            y_o    <= '0;
        end else if (state_q != RUN) begin
            hs_o   <= ~HS_POL;
            vs_o   <= ~VS_POL;
            de_o   <= 1'b0;
            sof_o  <= 1'b0;
            data_o <= '0;
            x_o    <= '0;
            y_o    <= '0;
        end else begin
            hs_o   <= vo.hs;
            vs_o   <= vo.vs;
            de_o   <= vo.de;
            sof_o  <= vo.sof;
            data_o <= vo.data;
            x_o    <= h[HW-1:0];
            y_o    <= v;
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a small 12x6 raster: directed frame sequence with
// randomized pattern choices, checked against an arithmetic model of the raster.
module tb_vid_timing_gen;

    localparam int HWID = 8,  HST = 10, HSY = 2, HTOT = 12;
    localparam int VHGT = 4,  VST = 5,  VSY = 1, VTOT = 6;
    localparam int KH = 2, KV = 2;
    localparam int FRAME = HTOT * VTOT;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [1:0]  pattern_i;
    logic        hs_o, vs_o, de_o, sof_o;
    logic [23:0] data_o;
    logic [3:0]  x_o;
    logic [2:0]  y_o;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    vid_timing_gen #(
        .H_WIDTH(HWID), .H_START(HST), .H_SYNC(HSY), .H_TOTAL(HTOT),
        .V_HEIGHT(VHGT), .V_START(VST), .V_SYNC(VSY), .V_TOTAL(VTOT),
        .HS_POL(1'b1), .VS_POL(1'b1), .KH(KH), .KV(KV)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pattern_i(pattern_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o),
        .x_o(x_o), .y_o(y_o), .sof_o(sof_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int x, input int y, input int pat);
        int         bar;
        logic [7:0] g;
        if (!(x < HWID && y < VHGT)) return 24'h0;
        case (pat)
            0: begin
                bar = x / (HWID / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: begin
                g = x[7:0];
                return {g, g, g};
            end
            2: return (((x / KH) + (y / KV)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_de"},   de_o,   0);
        chk({tag, "_hs"},   hs_o,   0);
        chk({tag, "_vs"},   vs_o,   0);
        chk({tag, "_sof"},  sof_o,  0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_x"},    x_o,    0);
        chk({tag, "_y"},    y_o,    0);
    endtask

    // Checks one full frame of outputs; the next frame's en/pattern are set just
    // before the wrap edge, with a throwaway pattern change mid-frame.
    task automatic run_frame(input int pat, input bit drop, input bit en_next, input int next_pat);
        int de_cnt  = 0;
        int sof_cnt = 0;
        for (int t = 0; t < FRAME; t++) begin
            int x, y;
            x = t % HTOT;
            y = t / HTOT;
            @(negedge clk_i);
            chk("x",    x_o,    x);
            chk("y",    y_o,    y);
            chk("de",   de_o,   (x < HWID && y < VHGT));
            chk("hs",   hs_o,   (x >= HST && x < HST + HSY));
            chk("vs",   vs_o,   (y >= VST && y < VST + VSY));
            chk("sof",  sof_o,  (x == 0 && y == 0));
            chk("data", data_o, ref_pix(x, y, pat));
            de_cnt  += int'(de_o);
            sof_cnt += int'(sof_o);
            if (drop && t == 2 * HTOT) en_i = 1'b0;
            if (t == 30) pattern_i = 2'($urandom_range(0, 3));
            if (t == FRAME - 2) begin
                en_i      = en_next;
                pattern_i = 2'(next_pat);
            end
        end
        chk("de_per_frame",  de_cnt,  HWID * VHGT);
        chk("sof_per_frame", sof_cnt, 1);
    endtask

    initial begin
        int p, np;
        rst_i     = 1'b1;
        en_i      = 1'b0;
        pattern_i = 2'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Idle with en low
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            chk_idle("idle");
        end

        // Start: outputs still idle one edge after en is sampled, active the next
        en_i      = 1'b1;
        pattern_i = 2'd1;
        @(negedge clk_i);
        chk("start_de_lat", de_o, 0);
        run_frame(1, 1'b0, 1'b1, 2);
        run_frame(2, 1'b0, 1'b1, 0);
        run_frame(0, 1'b0, 1'b1, 3);
        p = 3;
        for (int f = 0; f < 3; f++) begin
            np = int'($urandom_range(0, 3));
            run_frame(p, 1'b0, 1'b1, np);
            p = np;
        end
        // en dropped at line 2: frame must still complete, then go idle
        run_frame(p, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk_idle("stop");
            pattern_i = 2'($urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of an active line
        en_i      = 1'b1;
        pattern_i = 2'd3;
        @(negedge clk_i);
        repeat (HTOT + 2) @(negedge clk_i);
        chk("pre_rst_de",   de_o,   1);
        chk("pre_rst_x",    x_o,    1);
        chk("pre_rst_data", data_o, 24'hFFFFFF);
        #2 rst_i = 1'b1;
        #1;
        chk_idle("async_rst");
        en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk_idle("post_rst");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
